// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: hands the vertical-blanking update window to NREQ game-logic engines
// round-robin, then pulses commit so the renderer latches new state tear-free.
// Latency: ARB->gnt 1 clk, release->gnt low 1 clk; the engines hold off (level req) until granted.
// Ports: clk/reset (sync, active-high); p_tick/x/y from vga_sync; req/done per engine;
//        gnt (one-hot), commit, frame_start, frame_cnt, render_en, overrun.
// Option: SKIP_COMMIT_ON_OVERRUN_EN suppresses the commit pulse in a frame that had an overrun.
module frame_update_scheduler #(
  parameter int NREQ          = 4,
  parameter int V_DISPLAY     = 480,
  parameter int V_MAX         = 524,
  parameter int DEADLINE_LINE = 520,
  parameter int GRANT_TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p_tick,
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic            commit,
  output logic            frame_start,
  output logic [15:0]     frame_cnt,
  output logic            render_en,
  output logic            overrun
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [9:0] Y_VDISP = 10'(V_DISPLAY);
  localparam logic [9:0] Y_VMAX  = 10'(V_MAX);
  localparam logic [9:0] Y_DL    = 10'(DEADLINE_LINE);
  localparam logic [TW-1:0] T_LAST = TW'(GRANT_TIMEOUT - 1);

  typedef enum logic [2:0] {S_ACTIVE, S_ARB, S_GRANT, S_COMMIT, S_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [9:0]      r_y_q;
  logic [NREQ-1:0] r_served, w_served_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_commit, w_commit_nxt;
  logic            r_frame_start, w_frame_start_nxt;
  logic [15:0]     r_frame_cnt, w_frame_cnt_nxt;
  logic            r_render_en;
  logic            r_overrun, w_overrun_nxt;
`ifdef SKIP_COMMIT_ON_OVERRUN_EN
  logic            r_ovr_seen, w_ovr_seen_nxt;
`endif

  logic            w_vblank_rise, w_wrap;
  logic            w_rel_soft, w_rel_to, w_rel_dl;
  logic [NREQ-1:0] w_pend, w_rot;
  logic [2*NREQ-1:0] w_dbl;
  logic            w_pick_vld;
  logic [IW-1:0]   w_off, w_pick_idx;
  logic            w_unused_vga;

  // The scheduler works on line granularity only; pixel position is not needed.
  assign w_unused_vga = ^{p_tick, x};

  assign w_vblank_rise = (y == Y_VDISP) && (r_y_q == Y_VDISP - 10'd1);
  assign w_wrap        = (y == 10'd0) && (r_y_q == Y_VMAX);

  // done on a non-granted index never reaches here: only the held index is looked at.
  assign w_rel_soft = done[r_idx] || !req[r_idx];
  assign w_rel_to   = (r_timer == T_LAST);
  assign w_rel_dl   = (y == Y_DL);

  // Round-robin pick: rotate pending so rr_ptr sits at bit 0, take the lowest set bit,
  // then rotate the offset back.
  always_comb begin
    w_pend     = req & ~r_served;
    w_dbl      = {w_pend, w_pend} >> r_rr_ptr;
    w_rot      = w_dbl[NREQ-1:0];
    w_pick_vld = 1'b0;
    w_off      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pick_vld = 1'b1;
        w_off      = IW'(k);
      end
    end
    w_pick_idx = IW'((int'(r_rr_ptr) + int'(w_off)) % NREQ);
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_served_nxt      = r_served;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_idx_nxt         = r_idx;
    w_timer_nxt       = r_timer;
    w_gnt_nxt         = r_gnt;
    w_commit_nxt      = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_overrun_nxt     = 1'b0;
`ifdef SKIP_COMMIT_ON_OVERRUN_EN
    w_ovr_seen_nxt    = r_ovr_seen;
`endif
    case (r_state)
      S_ACTIVE: begin
        if (w_vblank_rise) begin
          w_served_nxt = '0;
          w_state_nxt  = S_ARB;
`ifdef SKIP_COMMIT_ON_OVERRUN_EN
          w_ovr_seen_nxt = 1'b0;
`endif
        end
      end
      S_ARB: begin
        if ((y >= Y_DL) || !w_pick_vld) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_gnt_nxt   = NREQ'(1) << w_pick_idx;
          w_idx_nxt   = w_pick_idx;
          w_timer_nxt = '0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_rel_soft || w_rel_to || w_rel_dl) begin
          w_gnt_nxt           = '0;
          w_served_nxt[r_idx] = 1'b1;
          w_rr_ptr_nxt        = IW'((int'(r_idx) + 1) % NREQ);
          // Deadline always ends the window, even if the engine finished that same cycle.
          w_state_nxt         = w_rel_dl ? S_COMMIT : S_ARB;
          w_overrun_nxt       = !w_rel_soft;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_COMMIT: begin
`ifdef SKIP_COMMIT_ON_OVERRUN_EN
        w_commit_nxt = ~r_ovr_seen;
`else
        w_commit_nxt = 1'b1;
`endif
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
      end
      default: w_state_nxt = S_WAIT;
    endcase
`ifdef SKIP_COMMIT_ON_OVERRUN_EN
    if (w_overrun_nxt) w_ovr_seen_nxt = 1'b1;
`endif
    // Frame wrap resynchronises the FSM from any state (covers a lost vblank).
    if (w_wrap) begin
      w_state_nxt       = S_ACTIVE;
      w_gnt_nxt         = '0;
      w_frame_start_nxt = 1'b1;
      w_frame_cnt_nxt   = r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_WAIT;
      r_y_q         <= '0;
      r_served      <= '0;
      r_rr_ptr      <= '0;
      r_idx         <= '0;
      r_timer       <= '0;
      r_gnt         <= '0;
      r_commit      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
      r_render_en   <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef SKIP_COMMIT_ON_OVERRUN_EN
      r_ovr_seen    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_y_q         <= y;
      r_served      <= w_served_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_idx         <= w_idx_nxt;
      r_timer       <= w_timer_nxt;
      r_gnt         <= w_gnt_nxt;
      r_commit      <= w_commit_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_render_en   <= (y < Y_VDISP);
      r_overrun     <= w_overrun_nxt;
`ifdef SKIP_COMMIT_ON_OVERRUN_EN
      r_ovr_seen    <= w_ovr_seen_nxt;
`endif
    end
  end

  assign gnt         = r_gnt;
  assign commit      = r_commit;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
  assign render_en   = r_render_en;
  assign overrun     = r_overrun;
endmodule
